audio_buffer_player: RTL and testbench

Consumer stage directly downstream of the FAT32/WAV reader. Owns a two-bank ping-pong sample memory, accepts the reader's buffer-write handshake, and plays stored 8-bit unsigned PCM at a fixed 44.1 kHz rate derived from `clk`. Presents each sample as a registered word and, optionally, as a PWM audio output.

---
 rtl/audio_buffer_player.sv | 157 +++++++++++++++
 tb/tb_audio_buffer_player.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_buffer_player.sv
// audio_buffer_player
//   Consumer stage behind the FAT32/WAV reader. Two-bank ping-pong sample
//   memory filled by the reader, drained at SAMPLE_HZ into a registered 8-bit
//   unsigned PCM word and (optionally) a PWM pin.
//
//   Optional feature: define PLAYER_PWM_EN to build the 8-bit PWM modulator;
//   without it pwm_o is tied low and no counter exists.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   buf_addr_i      write offset inside the current write bank
//   buf_wren_i      write strobe (dropped while the write bank is full)
//   buf_data_i      [7:0] sample, [8] last-sample marker
//   buf_filled_i    pulse: write bank complete, hand it to the player
//   buf_empty_o     write bank is free for the reader
//   sample_o        current output sample (8'h80 = silence)
//   sample_valid_o  pulse when sample_o is reloaded from the buffer
//   underrun_o      pulse when a playback tick finds no valid bank
//   pwm_o           PWM audio, duty sample_o/256, period 256 clk
module audio_buffer_player #(
  parameter int CLK_HZ           = 50_000_000,
  parameter int SAMPLE_HZ        = 44100,
  parameter int BUFFER_ADDR_BITS = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BUFFER_ADDR_BITS-1:0] buf_addr_i,
  input  logic                        buf_wren_i,
  input  logic [8:0]                  buf_data_i,
  input  logic                        buf_filled_i,
  output logic                        buf_empty_o,
  output logic [7:0]                  sample_o,
  output logic                        sample_valid_o,
  output logic                        underrun_o,
  output logic                        pwm_o
);
  localparam int AW    = BUFFER_ADDR_BITS;
  localparam int DEPTH = 2 ** (AW + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUTPUT} state_t;

  state_t          state, state_nx;
  logic [1:0]      valid, valid_nx;
  logic            wr_bank, rd_bank;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     acc;
  logic [32:0]     acc_sum;
  logic [8:0]      mem [DEPTH];
  logic [8:0]      rd_data;
  logic            tick, wr_ok, fill_ok;
  logic            rd_en, load_smp, underrun_nx, advance, rel_bank;

  assign buf_empty_o = !valid[wr_bank];
  assign wr_ok       = buf_wren_i && buf_empty_o;
  assign fill_ok     = buf_filled_i && buf_empty_o;

  // Fractional divider: one extra bit so the compare cannot wrap.
  assign acc_sum = {1'b0, acc} + 33'(SAMPLE_HZ);
  assign tick    = acc_sum >= 33'(CLK_HZ);

  // Sample RAM, bank bit on top. A write in the same cycle as a fill still
  // uses the pre-toggle wr_bank.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_bank, buf_addr_i}] <= buf_data_i;
    if (rd_en) rd_data <= mem[{rd_bank, rd_ptr}];
  end

  // Read is issued on the tick; rd_data is valid during FETCH, so sample_o is
  // loaded on the FETCH->OUTPUT edge (visible tick+2). OUTPUT does the pointer
  // and bank bookkeeping, so a released bank shows up empty at tick+3.
  always_comb begin
    state_nx    = state;
    rd_en       = 1'b0;
    load_smp    = 1'b0;
    underrun_nx = 1'b0;
    advance     = 1'b0;
    rel_bank    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          if (valid[rd_bank]) begin
            rd_en    = 1'b1;
            state_nx = S_FETCH;
          end else begin
            underrun_nx = 1'b1;
          end
        end
      end
      S_FETCH: begin
        load_smp = 1'b1;
        state_nx = S_OUTPUT;
      end
      S_OUTPUT: begin
        advance  = 1'b1;
        rel_bank = rd_data[8] || (&rd_ptr);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Release and fill never target the same bit: a fill needs the bank
  // invalid, a release needs it valid. Both apply in the same cycle.
  always_comb begin
    valid_nx = valid;
    if (rel_bank) valid_nx[rd_bank] = 1'b0;
    if (fill_ok)  valid_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      valid          <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      rd_ptr         <= '0;
      acc            <= '0;
      sample_o       <= 8'h80;
      sample_valid_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      state          <= state_nx;
      acc            <= tick ? 32'(acc_sum - 33'(CLK_HZ)) : acc_sum[31:0];
      valid          <= valid_nx;
      sample_valid_o <= load_smp;
      underrun_o     <= underrun_nx;
      if (load_smp)         sample_o <= rd_data[7:0];
      else if (underrun_nx) sample_o <= 8'h80;
      if (fill_ok) wr_bank <= !wr_bank;
      if (advance) begin
        if (rel_bank) begin
          rd_bank <= !rd_bank;
          rd_ptr  <= '0;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

`ifdef PLAYER_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_o   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_o   <= pwm_cnt < sample_o;
    end
  end
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_buffer_player.sv
// Bench for audio_buffer_player: table of writer vectors with expected
// buf_empty_o, a model of the two banks that pushes expected samples into a
// scoreboard on each accepted fill, and a negedge monitor that pops and
// compares every sample_valid_o pulse and checks tick phase. A second
// instance with a slow tick holds one sample long enough to measure PWM duty.
module tb_audio_buffer_player;
  localparam int CLK_HZ    = 441000;
  localparam int SAMPLE_HZ = 44100;
  localparam int P_CLK_HZ  = 44100 * 600;
  localparam int AW        = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] buf_addr_i = '0;
  logic          buf_wren_i = 1'b0;
  logic [8:0]    buf_data_i = '0;
  logic          buf_filled_i = 1'b0;
  logic          buf_empty_o, sample_valid_o, underrun_o, pwm_o;
  logic [7:0]    sample_o;

  logic          p_rst_n = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic          p_wren = 1'b0;
  logic [8:0]    p_data = '0;
  logic          p_filled = 1'b0;
  logic          p_empty, p_valid, p_underrun, p_pwm;
  logic [7:0]    p_sample;

  always #5 clk = ~clk;

  audio_buffer_player #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .BUFFER_ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n), .buf_addr_i(buf_addr_i), .buf_wren_i(buf_wren_i),
    .buf_data_i(buf_data_i), .buf_filled_i(buf_filled_i), .buf_empty_o(buf_empty_o),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .underrun_o(underrun_o), .pwm_o(pwm_o));

  audio_buffer_player #(.CLK_HZ(P_CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .BUFFER_ADDR_BITS(AW)) u_pwm (
    .clk(clk), .rst_n(p_rst_n), .buf_addr_i(p_addr), .buf_wren_i(p_wren),
    .buf_data_i(p_data), .buf_filled_i(p_filled), .buf_empty_o(p_empty),
    .sample_o(p_sample), .sample_valid_o(p_valid), .underrun_o(p_underrun), .pwm_o(p_pwm));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed { logic [7:0] smp; logic last; logic bank; } exp_t;
  exp_t       sb_q[$];
  logic [8:0] mmem [2][8];
  logic [1:0] mvalid = '0;
  logic       mwr = 1'b0;

  // Tick model from the divider formula; tick_cyc = cycle in which tick fired.
  int      cyc = 0;
  int      tick_cyc = -100;
  longint  macc = 0;
  int      ur_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) macc <= 0;
    else if (macc + SAMPLE_HZ >= CLK_HZ) begin
      macc     <= macc + SAMPLE_HZ - CLK_HZ;
      tick_cyc <= cyc;
    end else macc <= macc + SAMPLE_HZ;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sample_valid_o) begin
        check("sample_phase", cyc, tick_cyc + 2);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sample: got %0h, expected no sample", sample_o);
        end else begin
          e = sb_q.pop_front();
          check("sample_data", sample_o, e.smp);
          if (e.last) mvalid[e.bank] = 1'b0;
        end
      end
      if (underrun_o) begin
        ur_cnt++;
        check("underrun_phase", cyc, tick_cyc + 1);
        check("underrun_level", sample_o, 8'h80);
      end
    end
  end

  // One writer cycle: drive at negedge, model the same edge, release.
  task automatic drive(input logic wren, input logic [AW-1:0] addr,
                       input logic [8:0] data, input logic filled);
    buf_wren_i = wren; buf_addr_i = addr; buf_data_i = data; buf_filled_i = filled;
    if (wren && !mvalid[mwr]) mmem[mwr][addr] = data;
    if (filled && !mvalid[mwr]) begin
      for (int k = 0; k < 8; k++) begin
        exp_t e;
        e.smp  = mmem[mwr][k][7:0];
        e.last = mmem[mwr][k][8] || (k == 7);
        e.bank = mwr;
        sb_q.push_back(e);
        if (e.last) break;
      end
      mvalid[mwr] = 1'b1;
      mwr = ~mwr;
    end
    @(negedge clk);
    buf_wren_i = 1'b0; buf_filled_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int b = 0;
    while (sb_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    check({name, "_drained"}, sb_q.size(), 0);
  endtask

  // After a bank is released the very next tick must underrun exactly once.
  task automatic expect_underrun(input string name);
    int base = ur_cnt;
    repeat (12) @(negedge clk);
    check({name, "_underrun_after"}, ur_cnt - base, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wren;
    logic [AW-1:0] addr;
    logic [8:0]    data;
    logic          filled;
    logic          exp_empty;
    logic          drain;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic wren, input int addr, input int data,
                     input logic filled, input logic exp_empty, input logic drain);
    vec_t v;
    v.wren = wren; v.addr = AW'(addr); v.data = 9'(data);
    v.filled = filled; v.exp_empty = exp_empty; v.drain = drain;
    vt.push_back(v);
  endtask

  initial begin
    int base, b, hi;
    logic seen;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) mmem[i][j] = '0;

    // single bank 0x10..0x17: bank 1 stays free so empty stays 1
    for (int i = 0; i < 8; i++) add(1, i, 'h10 + i, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1);
    // last marker at addr 2 (lands in bank 1)
    add(1, 0, 'h020, 0, 1, 0);
    add(1, 1, 'h021, 0, 1, 0);
    add(1, 2, 'h122, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1);
    // ping-pong: bank 0 then bank 1, then writes into a full bank are dropped
    for (int i = 0; i < 8; i++) add(1, i, 'h30 + i, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(1, i, 'h40 + i, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0);
    add(1, 0, 'h0FF, 0, 0, 0);
    add(1, 7, 'h1FF, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_empty", buf_empty_o, 1);
    check("rst_sample", sample_o, 8'h80);
    check("rst_valid", sample_valid_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_pwm", pwm_o, 0);

    // idle tick rate: underruns every 10 cycles (phase checked by monitor)
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("idle_underruns", ur_cnt, 4);
    check("idle_level", sample_o, 8'h80);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].wren, vt[i].addr, vt[i].data, vt[i].filled);
      check($sformatf("vec%0d_empty", i), buf_empty_o, vt[i].exp_empty);
      if (vt[i].drain) begin
        wait_drain($sformatf("vec%0d", i));
        expect_underrun($sformatf("vec%0d", i));
      end
    end

    // ping-pong release: empty low while 0x37 shows, high one cycle later
    seen = 1'b0;
    b = 0;
    while (!seen && b < 200) begin
      @(negedge clk);
      b++;
      if (sample_valid_o && sample_o == 8'h37) seen = 1'b1;
    end
    check("pp_last_b0_seen", seen, 1);
    check("pp_empty_t2", buf_empty_o, 0);
    base = ur_cnt;
    @(negedge clk);
    check("pp_empty_t3", buf_empty_o, 1);
    wait_drain("pp_b1");
    check("pp_no_underrun", ur_cnt - base, 0);
    expect_underrun("pp_b1");

    // reset right after a fill discards the bank
    drive(1, 0, 'h055, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    mvalid = '0;
    mwr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_empty", buf_empty_o, 1);
    check("midrst_sample", sample_o, 8'h80);
    base = ur_cnt;
    repeat (30) @(negedge clk);
    check("midrst_underruns", ur_cnt - base, 3);

    // PWM duty with sample 0x40 held by the slow instance
    p_rst_n = 1'b1;
    @(negedge clk);
    p_wren = 1'b1; p_addr = '0; p_data = 9'h140;
    @(negedge clk);
    p_wren = 1'b0; p_filled = 1'b1;
    @(negedge clk);
    p_filled = 1'b0;
    b = 0;
    while (!p_valid && b < 1500) begin
      @(negedge clk);
      b++;
    end
    check("pwm_sample_valid", p_valid, 1);
    check("pwm_sample", p_sample, 8'h40);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (p_pwm) hi++;
      @(negedge clk);
    end
`ifdef PLAYER_PWM_EN
    check("pwm_high_count", hi, 64);
`else
    check("pwm_high_count", hi, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
